serial_port: RTL and testbench

- FIFO-buffered 8N1 UART; the serial-side endpoint of the CPU I/O controller's serial interface.
- Accepts bytes from the controller's write strobe, buffers them, and shifts them out on tx.
- Deserialises rx into a receive FIFO that the controller drains with its read strobe and empty flag.
- Sits between the I/O controller and the DE0-Nano GPIO serial pins.

---
 rtl/serial_port_pkg.sv | 18 +
 rtl/serial_fifo.sv | 69 ++++++
 rtl/serial_port.sv | 252 +++++++++++++++++++++++++
 tb/tb_serial_port.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_port_pkg.sv
// Shared definitions for the serial port: FSM state encoding and frame constants.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package serial_port_pkg;

    // Common encoding for the TX and RX frame state machines.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } ser_state_e;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud
    localparam int DEFAULT_FIFO_DEPTH   = 16;

endpackage

// File: rtl/serial_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible on dout while empty=0.
// Latency: a push is visible on dout the cycle after the push edge; a pop advances dout the next cycle.
// Backpressure: push ignored while full=1, pop ignored while empty=1; both flags are registered.
module serial_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Next pointer/count state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        push_ok  = push & ~full_q;
        pop_ok   = pop & ~empty_q;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        full_d   = (count_d == (AW+1)'(DEPTH));
        empty_d  = (count_d == '0);
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Stale storage is masked so the head reads zero whenever the FIFO is empty.
    assign dout  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/serial_port.sv
// FIFO-buffered 8N1 UART: write-strobe TX FIFO to serial tx, serial rx to FWFT RX FIFO.
// Latency: tx falls one edge after a write from idle; a received byte shows on data_out one cycle after the stop sample.
// Backpressure: writes ignored while full=1; received bytes dropped with an overrun pulse when the RX FIFO is full.
module serial_port
    import serial_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       write,
    input  logic [7:0] data_in,
    output logic       full,
    input  logic       read,
    output logic [7:0] data_out,
    output logic       empty,
    output logic       tx,
    input  logic       rx,
    output logic       frame_error,
    output logic       overrun
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

    // ---------------- TX side ----------------
    logic                 tx_pop;
    logic                 tx_empty;
    logic [DATA_BITS-1:0] tx_head;

    ser_state_e           tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d;

    serial_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (write),
        .din     (data_in),
        .pop     (tx_pop),
        .dout    (tx_head),
        .full    (full),
        .empty   (tx_empty)
    );

    // TX framing: tx is registered and changes on the same edge the FSM changes bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_d       = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_d       = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit so queued bytes go out gap-free.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_d       = 1'b0;
                        tx_state_d = ST_START;
                    end else begin
                        tx_d       = 1'b1;
                        tx_state_d = ST_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
        endcase
    end

    // TX FSM state and registered serial output (idle high).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    assign tx = tx_q;

    // ---------------- RX side ----------------
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic                 rx_full;

    ser_state_e           rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_push_q, rx_push_d;
    logic                 frame_error_q, frame_error_d;
    logic                 overrun_q, overrun_d;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle line is high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX framing: re-check start at half a bit, then sample each bit mid-cell.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_push_d     = 1'b0;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // A line already back high here was a glitch, not a start bit.
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = ST_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    if (!rx_sync_q) begin
                        frame_error_d = 1'b1;
                    end else if (rx_full) begin
                        overrun_d = 1'b1;
                    end else begin
                        rx_push_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
        endcase
    end

    // RX FSM state, assembled byte and registered push/status pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q    <= ST_IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_push_q     <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_push_q     <= rx_push_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    // rx_shift_q holds the byte until the next frame's first data sample, well after the push.
    serial_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (rx_push_q),
        .din     (rx_shift_q),
        .pop     (read),
        .dout    (data_out),
        .full    (rx_full),
        .empty   (empty)
    );

    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_serial_port.sv
// Bench for serial_port with a timeline model of tx and a byte-queue model of the RX FIFO.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_port;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       full;
    logic       read = 1'b0;
    logic [7:0] data_out;
    logic       empty;
    logic       tx;
    logic       rx_line;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       frame_error;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    // Model state: frame start edges and bytes on the tx line, bytes expected in the RX FIFO.
    int         cyc = 0;
    int         last_end = 0;
    int         fs[$];
    logic [7:0] fb[$];
    logic [7:0] rx_exp[$];
    logic       m_tx = 1'b1;
    logic       m_full = 1'b0;
    int         n_acc = 0;
    int         exp_ov = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;

    assign rx_line = loop_en ? tx : rx_drv;

    serial_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .write       (write),
        .data_in     (data_in),
        .full        (full),
        .read        (read),
        .data_out    (data_out),
        .empty       (empty),
        .tx          (tx),
        .rx          (rx_line),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: advances once per rising edge, cleared by reset.
    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                cyc = 0;
                last_end = 0;
                fs.delete();
                fb.delete();
                rx_exp.delete();
                m_tx = 1'b1;
                m_full = 1'b0;
            end else begin
                int st;
                int pending;
                cyc++;
                if (write && !m_full) begin
                    st = (cyc + 1 > last_end) ? cyc + 1 : last_end;
                    fs.push_back(st);
                    fb.push_back(data_in);
                    last_end = st + FRAME;
                    n_acc++;
                    if (loop_en) begin
                        if (rx_exp.size() >= DEPTH) exp_ov++;
                        else rx_exp.push_back(data_in);
                    end
                end
                if (read && !empty && rx_exp.size() > 0) void'(rx_exp.pop_front());
                while (fs.size() > 0 && fs[0] + FRAME <= cyc) begin
                    void'(fs.pop_front());
                    void'(fb.pop_front());
                end
                m_tx = 1'b1;
                if (fs.size() > 0 && fs[0] <= cyc) begin
                    int b;
                    b = (cyc - fs[0]) / CPB;
                    if (b == 0) m_tx = 1'b0;
                    else if (b <= 8) m_tx = fb[0][b-1];
                    else m_tx = 1'b1;
                end
                pending = 0;
                foreach (fs[i]) if (fs[i] > cyc) pending++;
                m_full = (pending == DEPTH);
            end
        end
    end

    // Compare process: every falling edge out of reset.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                chk("tx_line", tx, m_tx);
                chk("tx_full", full, m_full);
                if (!empty) begin
                    if (rx_exp.size() == 0) chk("rx_unexpected_data", empty, 1);
                    else chk("rx_head", data_out, rx_exp[0]);
                end
                if (frame_error) fe_cnt++;
                if (overrun) ov_cnt++;
            end
        end
    end

    task automatic wr(input logic [7:0] b);
        write = 1'b1;
        data_in = b;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic rd();
        read = 1'b1;
        @(negedge clock);
        read = 1'b0;
    endtask

    task automatic wait_not_empty(input int limit);
        int w = 0;
        while (empty && w < limit) begin
            @(negedge clock);
            w++;
        end
        chk("rx_arrival", empty, 0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drv = f[k];
            repeat (CPB) @(negedge clock);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] pat;

        // Reset values.
        #3 reset_n = 1'b0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_data_out", data_out, 0);
        chk("rst_frame_error", frame_error, 0);
        chk("rst_overrun", overrun, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // 1: single byte waveform.
        wr(8'hA5);
        chk("t1_tx_before", tx, 1);
        @(negedge clock);
        chk("t1_tx_start_edge", tx, 0);
        @(negedge clock);
        pat = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            chk("t1_tx_bit", tx, pat[k]);
            repeat (CPB) @(negedge clock);
        end
        chk("t1_tx_idle", tx, 1);
        chk("t1_full", full, 0);
        repeat (5) @(negedge clock);

        // 2: 20 consecutive writes, 17 accepted.
        n_acc = 0;
        write = 1'b1;
        data_in = 8'h10;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            chk("t2_full_after_write", full, (k >= 17) ? 1 : 0);
            if (k < 20) data_in = 8'h10 + 8'(k);
            else write = 1'b0;
        end
        chk("t2_accepted", n_acc, 17);
        repeat (17 * FRAME + 10) @(negedge clock);
        chk("t2_drained_tx", tx, 1);
        chk("t2_drained_full", full, 0);

        // 3: loopback of 16 bytes, read back every cycle.
        loop_en = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 16; i++) wr(8'(i));
        repeat (16 * FRAME + 20) @(negedge clock);
        for (int i = 0; i < 16; i++) begin
            chk("t3_empty", empty, 0);
            chk("t3_data", data_out, i);
            read = 1'b1;
            @(negedge clock);
        end
        read = 1'b0;
        chk("t3_empty_after", empty, 1);
        rd();
        chk("t3_read_while_empty", empty, 1);
        loop_en = 1'b0;
        repeat (4) @(negedge clock);

        // 4: direct RX: stop-bit error, glitch, then a clean byte.
        send_frame(8'h3C, 1'b0);
        repeat (20) @(negedge clock);
        chk("t4_frame_error_count", fe_cnt, 1);
        chk("t4_fe_empty", empty, 1);
        rx_drv = 1'b0;
        @(negedge clock);
        rx_drv = 1'b1;
        repeat (20) @(negedge clock);
        chk("t4_glitch_fe", fe_cnt, 1);
        chk("t4_glitch_ov", ov_cnt, 0);
        chk("t4_glitch_empty", empty, 1);
        rx_exp.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        wait_not_empty(20);
        chk("t4_direct_byte", data_out, 8'hC3);
        rd();
        chk("t4_direct_drained", empty, 1);

        // 5: 17 frames with no reads -> one overrun.
        loop_en = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 17; i++) wr(8'h40 + 8'(i));
        repeat (17 * FRAME + 20) @(negedge clock);
        chk("t5_overrun_count", ov_cnt, 1);
        chk("t5_model_overrun", exp_ov, 1);
        chk("t5_head", data_out, 8'h40);
        chk("t5_empty", empty, 0);
        for (int i = 0; i < 16; i++) begin
            chk("t5_drain", data_out, 8'h40 + i);
            rd();
        end
        chk("t5_drained", empty, 1);

        // 6: reset mid-frame on both directions, then a fresh round trip.
        wr(8'h5A);
        repeat (12) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_tx", tx, 1);
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_full", full, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        wr(8'h81);
        wait_not_empty(FRAME + 20);
        chk("t6_roundtrip", data_out, 8'h81);
        rd();
        chk("t6_drained", empty, 1);
        chk("final_frame_errors", fe_cnt, 1);
        chk("final_overruns", ov_cnt, 1);
        loop_en = 1'b0;
        repeat (4) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
